// File: rtl/alu_pkg.sv
// Shared op codes, compare codes and FSM state type for the sequential ALU core.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier: one partial product per clock, W steps after load.
module mul_seq #(
    parameter int unsigned W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   product,
    output logic             fin
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          run;
    logic [PW-1:0] addend;

    // product is the accumulator value after the current step, so the
    // caller can capture the full result on the same edge as the last step.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        product = acc + addend;
        fin     = run && (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= PW'(a);
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (fin) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// ALU with start/busy/done handshake: single-cycle logic/arith ops and a
// W-cycle sequential multiply; all results registered and held until the next op.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             carry,
    output logic             zero,
    output logic [1:0]       cmp
);

    localparam int unsigned RW = 2 * W;

    if (W < 2 || W > 16) begin : g_w_check
        $error("alu_seq_core: W must be in 2..16");
    end

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          accept_c;
    logic          mul_load_c;
    logic          sc_done_c;
    logic          mul_done_c;
    logic [W:0]    sum_c;
    logic [W-1:0]  alu_c;
    logic          alu_carry_c;
    logic [1:0]    cmp_in_c;
    logic [RW-1:0] product;
    logic          fin;

    function automatic logic [1:0] cmp_of(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == y) begin
            return CMP_EQ;
        end else if (x < y) begin
            return CMP_LT;
        end
        return CMP_GT;
    endfunction

    mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load_c),
        .a       (a),
        .b       (b),
        .product (product),
        .fin     (fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && op == OP_MUL) state_nx = MUL;
            MUL:     if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake decode; start is only honoured while idle.
    always_comb begin
        accept_c   = start && (state == IDLE);
        mul_load_c = accept_c && (op == OP_MUL);
        sc_done_c  = accept_c && (op != OP_MUL);
        mul_done_c = (state == MUL) && fin;
    end

    assign busy = (state == MUL);

    always_comb begin
        sum_c       = '0;
        alu_c       = '0;
        alu_carry_c = 1'b0;
        cmp_in_c    = cmp_of(a, b);
        case (op)
            OP_ADD: begin
                sum_c       = {1'b0, a} + {1'b0, b};
                alu_c       = sum_c[W-1:0];
                alu_carry_c = sum_c[W];
            end
            OP_SUB: begin
                sum_c       = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                alu_c       = sum_c[W-1:0];
                alu_carry_c = sum_c[W];
            end
            OP_AND:  alu_c = a & b;
            OP_OR:   alu_c = a | b;
            OP_XOR:  alu_c = a ^ b;
            OP_NOT:  alu_c = ~a;
            OP_CMP:  alu_c = W'(cmp_in_c);
            default: alu_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            cmp    <= CMP_EQ;
            opa    <= '0;
            opb    <= '0;
        end else begin
            done <= sc_done_c || mul_done_c;
            if (sc_done_c) begin
                result <= RW'(alu_c);
                carry  <= alu_carry_c;
                zero   <= (alu_c == '0);
                cmp    <= cmp_in_c;
            end else if (mul_done_c) begin
                result <= product;
                carry  <= 1'b0;
                zero   <= (product == '0);
                cmp    <= cmp_of(opa, opb);
            end
            if (accept_c) begin
                opa <= a;
                opb <= b;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: vector table, random ops against an arithmetic model,
// and hand sequences for busy/back-to-back/reset corners; second instance at W=12.
`timescale 1ns/1ps
module tb_alu_seq_core;

    localparam int unsigned W  = 6;
    localparam int unsigned W2 = 12;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op    = 3'd0;
    logic [W-1:0]    a     = '0;
    logic [W-1:0]    b     = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  result;
    logic            carry;
    logic            zero;
    logic [1:0]      cmp;

    logic            start_w = 1'b0;
    logic [2:0]      op_w    = 3'd0;
    logic [W2-1:0]   a_w     = '0;
    logic [W2-1:0]   b_w     = '0;
    logic            busy_w;
    logic            done_w;
    logic [2*W2-1:0] result_w;
    logic            carry_w;
    logic            zero_w;
    logic [1:0]      cmp_w;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     op;
        longint a;
        longint b;
        longint res;
        int     c;
        int     z;
        int     cm;
        int     lat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_seq_core #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .cmp(cmp)
    );

    alu_seq_core #(.W(W2)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .op(op_w), .a(a_w), .b(b_w),
        .busy(busy_w), .done(done_w), .result(result_w), .carry(carry_w), .zero(zero_w), .cmp(cmp_w)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference computed from the arithmetic definition of each op.
    function automatic void model(input int o, input longint x, input longint y,
                                  output longint r, output int c, output int z,
                                  output int cm, output int lat);
        longint m;
        m   = longint'(1) << W;
        cm  = (x == y) ? 0 : ((x < y) ? 1 : 2);
        c   = 0;
        lat = (o == 7) ? int'(W) + 1 : 1;
        case (o)
            0: begin r = (x + y) % m; c = ((x + y) >= m) ? 1 : 0; end
            1: begin r = (x - y + m) % m; c = (x >= y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (m - 1) - x;
            6: r = longint'(cm);
            default: r = x * y;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    task automatic run_op(input int o, input longint x, input longint y, output int lat);
        @(negedge clk);
        start = 1'b1; op = 3'(o); a = W'(x); b = W'(y);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic apply(input string tag, input int o, input longint x, input longint y,
                         input longint er, input int ec, input int ez, input int ecm,
                         input int elat);
        int lat;
        run_op(o, x, y, lat);
        chk({tag, " latency"}, longint'(lat), longint'(elat));
        chk({tag, " result"}, longint'(result), er);
        chk({tag, " carry"}, longint'(carry), longint'(ec));
        chk({tag, " zero"}, longint'(zero), longint'(ez));
        chk({tag, " cmp"}, longint'(cmp), longint'(ecm));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, longint'(done), 0);
        chk({tag, " result_held"}, longint'(result), er);
    endtask

    task automatic run_w(input int o, input longint x, input longint y, output int lat);
        @(negedge clk);
        start_w = 1'b1; op_w = 3'(o); a_w = W2'(x); b_w = W2'(y);
        @(negedge clk);
        start_w = 1'b0;
        lat = 1;
        while (!done_w && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int     lat;
        int     nb;
        int     seen;
        longint x;
        longint y;
        longint er;
        int     ec;
        int     ez;
        int     ecm;
        int     elat;
        int     o;

        tbl.push_back('{0, 63, 1, 0, 1, 1, 2, 1});
        tbl.push_back('{1, 5, 9, 'h3C, 0, 0, 1, 1});
        tbl.push_back('{1, 9, 9, 0, 1, 1, 0, 1});
        tbl.push_back('{2, 'h2A, 'h15, 0, 0, 1, 2, 1});
        tbl.push_back('{3, 'h2A, 'h15, 'h3F, 0, 0, 2, 1});
        tbl.push_back('{5, 'h0F, 3, 'h30, 0, 0, 2, 1});
        tbl.push_back('{6, 3, 40, 1, 0, 0, 1, 1});
        tbl.push_back('{6, 5, 5, 0, 0, 1, 0, 1});
        tbl.push_back('{7, 63, 63, 'hF81, 0, 0, 0, 7});
        tbl.push_back('{7, 0, 5, 0, 0, 1, 1, 7});
        tbl.push_back('{4, 7, 7, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 20, 22, 42, 0, 0, 1, 1});

        repeat (2) @(negedge clk);
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        chk("reset result", longint'(result), 0);
        chk("reset carry", longint'(carry), 0);
        chk("reset zero", longint'(zero), 0);
        chk("reset cmp", longint'(cmp), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                  tbl[i].c, tbl[i].z, tbl[i].cm, tbl[i].lat);
        end

        for (int i = 0; i < 120; i++) begin
            o = int'($urandom_range(0, 7));
            x = longint'($urandom_range(0, (1 << W) - 1));
            y = longint'($urandom_range(0, (1 << W) - 1));
            if (i % 10 == 0) y = x;
            model(o, x, y, er, ec, ez, ecm, elat);
            apply($sformatf("rnd%0d op%0d a%0d b%0d", i, o, x, y), o, x, y, er, ec, ez, ecm, elat);
        end

        // MUL with a start pulse during busy that must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = W'(63); b = W'(63);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nb = 0;
        while (!done && lat < 200) begin
            if (busy) nb++;
            if (lat == 2) begin
                start = 1'b1; op = 3'd0; a = W'(1); b = W'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("busy_ign latency", longint'(lat), longint'(W + 1));
        chk("busy_ign busy_cycles", longint'(nb), longint'(W));
        chk("busy_ign result", longint'(result), 'hF81);
        chk("busy_ign busy_at_done", longint'(busy), 0);
        @(negedge clk);
        chk("busy_ign no_extra_done", longint'(done), 0);
        chk("busy_ign result_held", longint'(result), 'hF81);

        // Back-to-back single-cycle ops.
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = W'('h2A); b = W'('h15);
        @(negedge clk);
        chk("b2b xor done", longint'(done), 1);
        chk("b2b xor result", longint'(result), 'h3F);
        op = 3'd2;
        @(negedge clk);
        start = 1'b0;
        chk("b2b and done", longint'(done), 1);
        chk("b2b and result", longint'(result), 0);
        chk("b2b and zero", longint'(zero), 1);
        @(negedge clk);
        chk("b2b done_low", longint'(done), 0);

        // Reset during a running multiply.
        apply("pre_rst", 0, 30, 12, 42, 0, 0, 2, 1);
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = W'(7); b = W'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst busy_before", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", longint'(busy), 0);
        chk("mid_rst result", longint'(result), 0);
        chk("mid_rst done", longint'(done), 0);
        chk("mid_rst cmp", longint'(cmp), 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("mid_rst no_done", longint'(seen), 0);
        rst_n = 1'b1;
        apply("post_rst mul", 7, 7, 5, 35, 0, 0, 2, int'(W) + 1);

        // Wider instance.
        run_w(7, 4095, 4095, lat);
        chk("w12 mul latency", longint'(lat), longint'(W2 + 1));
        chk("w12 mul result", longint'(result_w), 'hFFE001);
        chk("w12 mul carry", longint'(carry_w), 0);
        chk("w12 mul cmp", longint'(cmp_w), 0);
        run_w(6, 100, 3000, lat);
        chk("w12 cmp latency", longint'(lat), 1);
        chk("w12 cmp result", longint'(result_w), 1);
        chk("w12 cmp cmp", longint'(cmp_w), 1);
        chk("w12 cmp zero", longint'(zero_w), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
